// File: rtl/jesd_clock_monitor_if.sv
// rtl/jesd_clock_monitor_if.sv - toggle/clear inputs and status outputs of the JESD core clock monitor
interface jesd_clock_monitor_if #(
    parameter int CNT_W = 16
);
    logic             clk_toggle;
    logic             err_clear;
    logic [CNT_W-1:0] freq_count;
    logic             window_done;
    logic             clk_locked;
    logic             core_rst_n;
    logic             err_sticky;

    modport master (
        output clk_toggle, err_clear,
        input  freq_count, window_done, clk_locked, core_rst_n, err_sticky
    );

    modport slave (
        input  clk_toggle, err_clear,
        output freq_count, window_done, clk_locked, core_rst_n, err_sticky
    );
endinterface

// File: rtl/jesd_clock_monitor.sv
// rtl/jesd_clock_monitor.sv - JESD coreclk presence/frequency monitor with lock FSM; JESD_CLKMON_TIMEOUT_EN adds a no-edge timeout
module jesd_clock_monitor #(
    parameter int WINDOW_CYCLES  = 1024,
    parameter int CNT_W          = 16,
    parameter int EXP_MIN        = 200,
    parameter int EXP_MAX        = 210,
    parameter int LOCK_COUNT     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    jesd_clock_monitor_if.slave  mon
);
    localparam int WIN_W = $clog2(WINDOW_CYCLES);
    localparam int GC_W  = $clog2(LOCK_COUNT + 1);
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] EXP_MIN_C = CNT_W'(EXP_MIN);
    localparam logic [CNT_W-1:0] EXP_MAX_C = CNT_W'(EXP_MAX);
    localparam logic [GC_W-1:0]  LOCK_C    = GC_W'(LOCK_COUNT);

    if (WINDOW_CYCLES < 16 || LOCK_COUNT < 1 || TIMEOUT_CYCLES < 1 || EXP_MIN > EXP_MAX) begin : g_param_check
        $error("jesd_clock_monitor: illegal parameter set");
    end

    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

    state_t           state, state_nxt;
    logic [GC_W-1:0]  good_cnt, good_nxt;
    logic             err_set;

    logic             sync1, sync2, sync3;
    logic             tog_edge;
    logic [WIN_W-1:0] win_cnt;
    logic             win_last;
    logic [CNT_W-1:0] edge_cnt, edge_sum;
    logic             in_range;

    logic [CNT_W-1:0] freq_count_r;
    logic             window_done_r, clk_locked_r, core_rst_n_r, err_sticky_r;

    // Two flops resolve metastability; the third gives the previous level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= mon.clk_toggle;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign tog_edge = sync2 ^ sync3;
    assign win_last = (win_cnt == WIN_LAST);
    assign edge_sum = (edge_cnt == CNT_MAX) ? CNT_MAX
                                            : edge_cnt + {{(CNT_W-1){1'b0}}, tog_edge};
    assign in_range = (edge_sum >= EXP_MIN_C) && (edge_sum <= EXP_MAX_C);

    // An edge seen on the terminal cycle is folded into the closing window's count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt       <= '0;
            edge_cnt      <= '0;
            freq_count_r  <= '0;
            window_done_r <= 1'b0;
        end else begin
            win_cnt       <= win_last ? '0 : win_cnt + 1'b1;
            edge_cnt      <= win_last ? '0 : edge_sum;
            window_done_r <= win_last;
            if (win_last)
                freq_count_r <= edge_sum;
        end
    end

`ifdef JESD_CLKMON_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] idle_cnt;
    logic            to_armed;
    logic            timeout_hit;

    // Fires once per idle stretch; only a fresh edge re-arms it.
    assign timeout_hit = to_armed && !tog_edge && (idle_cnt == TO_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            to_armed <= 1'b0;
        end else if (tog_edge) begin
            idle_cnt <= '0;
            to_armed <= 1'b1;
        end else begin
            if (idle_cnt != TO_LIMIT)
                idle_cnt <= idle_cnt + 1'b1;
            if (timeout_hit)
                to_armed <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= UNLOCKED;
            good_cnt <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        err_set   = 1'b0;
        if (win_last) begin
            case (state)
                UNLOCKED: begin
                    if (in_range) begin
                        good_nxt  = GC_W'(1);
                        state_nxt = (LOCK_COUNT == 1) ? LOCKED : ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (in_range) begin
                        good_nxt = good_cnt + 1'b1;
                        if (good_nxt == LOCK_C)
                            state_nxt = LOCKED;
                    end else begin
                        good_nxt  = '0;
                        state_nxt = UNLOCKED;
                    end
                end
                LOCKED: begin
                    if (!in_range) begin
                        good_nxt  = '0;
                        state_nxt = UNLOCKED;
                        err_set   = 1'b1;
                    end
                end
                default: begin
                    good_nxt  = '0;
                    state_nxt = UNLOCKED;
                end
            endcase
        end
`ifdef JESD_CLKMON_TIMEOUT_EN
        if (timeout_hit) begin
            good_nxt  = '0;
            state_nxt = UNLOCKED;
            if (state == LOCKED)
                err_set = 1'b1;
        end
`endif
    end

    // Registered from the next state so lock status moves together with window_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_locked_r <= 1'b0;
            core_rst_n_r <= 1'b0;
            err_sticky_r <= 1'b0;
        end else begin
            clk_locked_r <= (state_nxt == LOCKED);
            core_rst_n_r <= (state_nxt == LOCKED);
            if (err_set)
                err_sticky_r <= 1'b1;
            else if (mon.err_clear)
                err_sticky_r <= 1'b0;
        end
    end

    assign mon.freq_count  = freq_count_r;
    assign mon.window_done = window_done_r;
    assign mon.clk_locked  = clk_locked_r;
    assign mon.core_rst_n  = core_rst_n_r;
    assign mon.err_sticky  = err_sticky_r;
endmodule
